// File: rtl/ret_stack8.sv
// ret_stack8 -- hardware return-address stack for the toy CPU.
//
// A CALL pushes the return address (PC+1). A RET pops it, and the registered
// pop result drives the PC parallel-load input. The stack grows downward:
// sp counts free entries, the top of stack lives at mem[sp], and a push
// writes mem[sp-1].
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   global enable for push/pop (clr_err ignores it)
//   push       in   push din this cycle
//   pop        in   pop the top entry this cycle
//   din        in   [WIDTH]  return address to push
//   clr_err    in   clears the sticky overflow/underflow flags
//   dout       out  [WIDTH]  registered popped address
//   dout_valid out  one-cycle pulse per accepted pop
//   sp         out  [SPW]    free-entry count (DEPTH when empty)
//   empty      out  sp == DEPTH
//   full       out  sp == 0
//   overflow   out  sticky: push attempted while full
//   underflow  out  sticky: pop attempted while empty
module ret_stack8 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int SPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [SPW-1:0]   sp,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage is deliberately not reset: an entry is only ever read after a
  // push has written it, so stale contents cannot leak to dout.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [SPW-1:0]   sp_q, sp_d, sp_m1;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [AW-1:0]    top_idx, push_idx;

  logic do_push, do_pop, do_swap, do_push_empty;

  assign empty = (sp_q == SPW'(DEPTH));
  assign full  = (sp_q == '0);

  assign sp_m1    = sp_q - SPW'(1);
  assign top_idx  = sp_q[AW-1:0];
  assign push_idx = sp_m1[AW-1:0];

  // Operation decode. Push+pop on a non-empty stack replaces the top in place;
  // on an empty stack only the push half is honoured (empty implies not full).
  assign do_push       = en & push & ~pop & ~full;
  assign do_pop        = en & pop & ~push & ~empty;
  assign do_swap       = en & push & pop & ~empty;
  assign do_push_empty = en & push & pop & empty;

  always_comb begin
    sp_d   = sp_q;
    dout_d = dout_q;
    dv_d   = 1'b0;
    if (do_push || do_push_empty) begin
      sp_d = sp_m1;
    end else if (do_pop) begin
      sp_d = sp_q + SPW'(1);
    end
    if (do_pop || do_swap) begin
      dout_d = mem[top_idx];
      dv_d   = 1'b1;
    end
    // New errors win over a simultaneous clear.
    ovf_d = (ovf_q & ~clr_err) | (en & push & ~pop & full);
    unf_d = (unf_q & ~clr_err) | (en & pop & empty);
  end

  always_ff @(posedge clk) begin
    if (do_push || do_push_empty) begin
      mem[push_idx] <= din;
    end else if (do_swap) begin
      mem[top_idx] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= SPW'(DEPTH);
      dout_q <= '1;
      dv_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign sp         = sp_q;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_ret_stack8.sv
module tb_ret_stack8;
  logic       clk = 1'b0;
  logic       rst, en, push, pop, clr_err;
  logic [7:0] din, dout;
  logic       dout_valid, empty, full, overflow, underflow;
  logic [3:0] sp;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];   // expected pop results, oldest first
  logic       want_dv;

  ret_stack8 #(.WIDTH(8), .DEPTH(8), .SPW(4)) dut (
    .clk(clk), .rst(rst), .en(en), .push(push), .pop(pop), .din(din),
    .clr_err(clr_err), .dout(dout), .dout_valid(dout_valid), .sp(sp),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the inputs, step past the edge, then score dout_valid
  // against the expectation and dout against the scoreboard head.
  task automatic cyc(input logic e, input logic pu, input logic po,
                     input logic [7:0] d, input logic ce,
                     input logic vld, input logic [7:0] exp_dout);
    en = e; push = pu; pop = po; din = d; clr_err = ce;
    want_dv = vld;
    if (vld) sb.push_back(exp_dout);
    @(posedge clk); #1;
    chk("dout_valid", {31'b0, dout_valid}, {31'b0, want_dv});
    if (dout_valid === 1'b1 && sb.size() > 0) chk("dout", {24'b0, dout}, {24'b0, sb.pop_front()});
    en = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_push(input logic [7:0] d);
    cyc(1'b1, 1'b1, 1'b0, d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_pop(input logic [7:0] exp_d);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, exp_d);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; push = 1'b0; pop = 1'b0; din = 8'h00; clr_err = 1'b0;
    want_dv = 1'b0;
    do_reset();

    // reset state
    chk("rst_sp", {28'b0, sp}, 32'd8);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_dout", {24'b0, dout}, 32'hFF);
    chk("rst_dv", {31'b0, dout_valid}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_unf", {31'b0, underflow}, 32'd0);
    idle();

    // LIFO order
    do_push(8'h10); do_push(8'h20); do_push(8'h30);
    chk("lifo_sp5", {28'b0, sp}, 32'd5);
    do_pop(8'h30); do_pop(8'h20); do_pop(8'h10);
    chk("lifo_sp8", {28'b0, sp}, 32'd8);
    idle();
    chk("lifo_dout_hold", {24'b0, dout}, 32'h10);

    // fill, then overflow
    for (int i = 1; i <= 8; i++) do_push(8'(i));
    chk("fill_full", {31'b0, full}, 32'd1);
    chk("fill_sp0", {28'b0, sp}, 32'd0);
    chk("fill_ovf0", {31'b0, overflow}, 32'd0);
    do_push(8'hAA);
    chk("ovf_set", {31'b0, overflow}, 32'd1);
    chk("ovf_sp0", {28'b0, sp}, 32'd0);
    do_pop(8'h08);
    chk("ovf_sp1", {28'b0, sp}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("ovf_clr", {31'b0, overflow}, 32'd0);
    for (int i = 7; i >= 1; i--) do_pop(8'(i));
    chk("drain_empty", {31'b0, empty}, 32'd1);

    // underflow after reset
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("unf_set", {31'b0, underflow}, 32'd1);
    chk("unf_dout", {24'b0, dout}, 32'hFF);
    chk("unf_sp", {28'b0, sp}, 32'd8);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("unf_clr", {31'b0, underflow}, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("unf_set_wins", {31'b0, underflow}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("unf_clr2", {31'b0, underflow}, 32'd0);

    // push+pop replaces the top
    do_push(8'h40);
    cyc(1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 8'h40);
    chk("swap_sp", {28'b0, sp}, 32'd7);
    do_pop(8'h55);
    chk("swap_sp8", {28'b0, sp}, 32'd8);
    // push+pop on empty: push only, underflow, no pulse
    cyc(1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
    chk("pe_sp", {28'b0, sp}, 32'd7);
    chk("pe_unf", {31'b0, underflow}, 32'd1);
    do_pop(8'h77);

    // enable low freezes push/pop; clr_err still acts
    do_push(8'hA1); do_push(8'hA2);
    chk("en_sp6", {28'b0, sp}, 32'd6);
    cyc(1'b0, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 8'h00);
    chk("en_push_sp", {28'b0, sp}, 32'd6);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("en_pop_sp", {28'b0, sp}, 32'd6);
    chk("en_pop_dout", {24'b0, dout}, 32'h77);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("en_clr_unf", {31'b0, underflow}, 32'd0);

    // async reset cancels a live dout_valid pulse
    do_pop(8'hA2);
    #2 rst = 1'b1;
    #1;
    chk("arst_dv", {31'b0, dout_valid}, 32'd0);
    chk("arst_sp", {28'b0, sp}, 32'd8);
    chk("arst_dout", {24'b0, dout}, 32'hFF);
    chk("arst_empty", {31'b0, empty}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    idle();
    chk("post_rst_sp", {28'b0, sp}, 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ret_stack8.md
Name: ret_stack8

Overview:
- Hardware return-address stack for the toy CPU.
- It is the counterpart of the program counter's load path. On a CALL the sequencer pushes the return address (PC+1). On a RET it pops that address, and the popped value drives the PC's parallel-load input.
- Internally the stack pointer is a loadable up/down counter: it counts down on push and up on pop.

Parameters:
- WIDTH, 8, width of each stored return address in bits.
- DEPTH, 8, number of stack entries (2..16).
- SPW, 4, stack-pointer width in bits. Must satisfy 2^SPW > DEPTH.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global enable. When 0, push and pop are ignored and all state holds.
- push  input  1  push din onto the stack this cycle.
- pop  input  1  pop the top entry this cycle.
- din  input  WIDTH  return address to push.
- clr_err  input  1  clears the sticky overflow and underflow flags.
- dout  output  WIDTH  registered popped address; feeds the PC load data.
- dout_valid  output  1  one-cycle pulse; dout holds a freshly popped value.
- sp  output  SPW  stack pointer, equal to the number of free entries.
- empty  output  1  high when sp == DEPTH.
- full  output  1  high when sp == 0.
- overflow  output  1  sticky; set when a push is attempted while full.
- underflow  output  1  sticky; set when a pop is attempted while empty.

Behaviour:
- Reset (rst=1, asynchronous, dominates everything):
  - sp = DEPTH, dout = all ones (8'hFF), dout_valid = 0, overflow = 0, underflow = 0.
  - Storage array is not reset; stale entries are never observable.
- en = 0: no state change, and dout_valid = 0 on the next cycle. clr_err still acts.
- Accepted push (en & push & ~pop & ~full): mem[sp-1] <= din, sp <= sp-1.
- Accepted pop (en & pop & ~push & ~empty): dout <= mem[sp], sp <= sp+1, dout_valid = 1 in the following cycle.
  - Latency: address visible on dout exactly 1 cycle after pop is sampled.
- Push and pop together (en & push & pop):
  - Not empty: replace the top. dout <= mem[sp], mem[sp] <= din, sp unchanged, dout_valid pulses.
  - Empty: push executes, the pop is dropped, underflow is set, dout_valid stays 0.
- Push when full: dropped; mem and sp unchanged; overflow set.
- Pop when empty: dropped; dout holds its previous value; dout_valid = 0; underflow set.
- dout holds its value until the next accepted pop. dout_valid is high for exactly one cycle per accepted pop.
- Sticky flags: clr_err = 1 clears both flags. If a new error occurs in the same cycle as clr_err, the set wins.
- empty and full are combinational decodes of sp. They are never simultaneously high for DEPTH >= 1.
- sp never leaves the range 0..DEPTH. There is no wrap-around, by construction.
- Reset asserted mid-operation: any pending dout_valid pulse is cancelled and sp returns to DEPTH immediately, asynchronously.

Test Plan:
- Reset, then idle: after rst deasserts, sp=8, empty=1, full=0, dout=8'hFF, dout_valid=0, both flags 0.
- Push 8'h10, 8'h20, 8'h30, then pop three times:
  - sp goes 8→5→8.
  - dout = 8'h30, 8'h20, 8'h10, each with a one-cycle dout_valid pulse one cycle after its pop.
- Fill with 8 pushes (8'h01..8'h08), then a 9th push of 8'hAA:
  - full=1, sp=0, overflow=1.
  - Popping once returns 8'h08, not 8'hAA.
- Pop on empty after reset: underflow=1, dout stays 8'hFF, dout_valid=0, sp=8.
  - clr_err pulse clears underflow.
  - clr_err asserted together with a new empty pop leaves underflow=1.
- Push+pop with stack holding [8'h40 on top]: dout=8'h40 with valid pulse, sp unchanged, and the next pop returns the new din (8'h55).
  - Push+pop on empty with din=8'h77: sp=7, underflow=1, no valid pulse.
- With 2 entries, drive en=0 and pulse push/pop: no change.
  - Assert rst mid-sequence: outputs return immediately to reset values.
